axis_bram_stream_engine: RTL and testbench

//  Parametrised second-generation AXI-Stream<->BRAM line adapter with full valid/ready backpressure.

---
 rtl/axis_bram_adapter_pkg.sv | 27 ++
 rtl/axis_bram_stream_engine_if.sv | 48 ++++
 rtl/axis_bram_line_buf.sv | 40 ++++
 rtl/axis_bram_stream_engine.sv | 169 ++++++++++++++++
 tb/tb_axis_bram_stream_engine.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_bram_adapter_pkg.sv
// Shared constants and FSM encoding for the AXI-Stream <-> BRAM line adapter.
package axis_bram_adapter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_FILL,
        W_COMMIT,
        R_ISSUE,
        R_WAIT,
        R_DRAIN,
        DONE
    } state_t;

    localparam int DEF_WORD_W         = 16;
    localparam int DEF_WORDS_PER_LINE = 36;
    localparam int DEF_ADDR_W         = 9;
    localparam int DEF_RD_LATENCY     = 1;

    function automatic int line_w(input int word_w, input int words);
        return word_w * words;
    endfunction

    function automatic int cnt_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/axis_bram_stream_engine_if.sv
// Control, stream and BRAM signals of the line adapter bundled as one interface.
interface axis_bram_stream_engine_if
    import axis_bram_adapter_pkg::*;
#(
    parameter int WORD_W         = DEF_WORD_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W
);
    localparam int LINE_W = line_w(WORD_W, WORDS_PER_LINE);

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_lines;
    logic              busy;
    logic              done;
    logic              err_tlast;
    logic [WORD_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [WORD_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [LINE_W-1:0] bram_wdata;
    logic [LINE_W-1:0] bram_rdata;

    modport master (
        input  start, mode, base_addr, num_lines,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, bram_rdata,
        output busy, done, err_tlast, s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output bram_en, bram_we, bram_addr, bram_wdata
    );

    modport slave (
        output start, mode, base_addr, num_lines,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, bram_rdata,
        input  busy, done, err_tlast, s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );

endinterface

// File: rtl/axis_bram_line_buf.sv
// One BRAM line of storage: word-indexed write for packing, parallel load and
// word-indexed read for unpacking. Clear takes priority so partial lines zero-fill.
module axis_bram_line_buf
    import axis_bram_adapter_pkg::*;
#(
    parameter  int WORD_W         = DEF_WORD_W,
    parameter  int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int LINE_W         = line_w(WORD_W, WORDS_PER_LINE),
    localparam int CNT_W          = cnt_w(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              ld_en,
    input  logic [LINE_W-1:0] ld_line,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_word,
    output logic [LINE_W-1:0] line
);
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_q <= '0;
        end else if (clr) begin
            line_q <= '0;
        end else if (ld_en) begin
            line_q <= ld_line;
        end else if (wr_en) begin
            line_q[int'(wr_idx) * WORD_W +: WORD_W] <= wr_word;
        end
    end

    assign rd_word = line_q[int'(rd_idx) * WORD_W +: WORD_W];
    assign line    = line_q;

endmodule

// File: rtl/axis_bram_stream_engine.sv
// AXI-Stream <-> BRAM line adapter: packs stream words into wide lines (write
// mode) or unpacks lines back into a stream with tlast (read mode).
module axis_bram_stream_engine
    import axis_bram_adapter_pkg::*;
#(
    parameter int WORD_W         = DEF_WORD_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int RD_LATENCY     = DEF_RD_LATENCY
) (
    input logic clk,
    input logic rstn,
    axis_bram_stream_engine_if.master bus
);
    localparam int                 LINE_W    = line_w(WORD_W, WORDS_PER_LINE);
    localparam int                 CNT_W     = cnt_w(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0]   WORD_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]    LINE_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [1:0]         LAST_WAIT = 2'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, nlines_q;
    logic [ADDR_W:0]   lcnt_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic [1:0]        wait_q;
    logic              early_q, err_q;
    logic              s_hs, m_hs, last_word, last_line, final_word, capture, clr;
    logic              busy, done, s_ready, m_valid, bram_en, bram_we;
    logic [WORD_W-1:0] rd_word;
    logic [LINE_W-1:0] line;

    assign s_hs       = (state_q == W_FILL) && bus.s_axis_tvalid;
    assign m_hs       = (state_q == R_DRAIN) && bus.m_axis_tready;
    assign last_word  = (wcnt_q == LAST_WORD);
    assign last_line  = ((lcnt_q + LINE_ONE) == {1'b0, nlines_q});
    assign final_word = last_word && last_line;
    assign capture    = (state_q == R_WAIT) && (wait_q == LAST_WAIT);
    assign clr        = ((state_q == IDLE) && bus.start) || (state_q == W_COMMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        s_ready = 1'b0;
        m_valid = 1'b0;
        bram_en = 1'b0;
        bram_we = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    if (bus.num_lines == '0) state_d = DONE;
                    else if (bus.mode)       state_d = W_FILL;
                    else                     state_d = R_ISSUE;
                end
            end
            W_FILL: begin
                s_ready = 1'b1;
                if (s_hs && (last_word || bus.s_axis_tlast)) state_d = W_COMMIT;
            end
            W_COMMIT: begin
                bram_en = 1'b1;
                bram_we = 1'b1;
                state_d = (last_line || early_q) ? DONE : W_FILL;
            end
            R_ISSUE: begin
                bram_en = 1'b1;
                state_d = R_WAIT;
            end
            R_WAIT: begin
                if (capture) state_d = R_DRAIN;
            end
            R_DRAIN: begin
                m_valid = 1'b1;
                if (m_hs && last_word) state_d = last_line ? DONE : R_ISSUE;
            end
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job parameters are captured only when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            nlines_q <= '0;
            lcnt_q   <= '0;
            wcnt_q   <= '0;
            wait_q   <= '0;
            early_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    addr_q   <= bus.base_addr;
                    nlines_q <= bus.num_lines;
                    lcnt_q   <= '0;
                    wcnt_q   <= '0;
                    wait_q   <= '0;
                    early_q  <= 1'b0;
                    err_q    <= 1'b0;
                end
                W_FILL: if (s_hs) begin
                    wcnt_q <= wcnt_q + WORD_ONE;
                    if (bus.s_axis_tlast && !final_word) early_q <= 1'b1;
                    if (bus.s_axis_tlast != final_word)  err_q   <= 1'b1;
                end
                W_COMMIT: begin
                    wcnt_q <= '0;
                    lcnt_q <= lcnt_q + LINE_ONE;
                    addr_q <= addr_q + ADDR_ONE;
                end
                R_ISSUE: wait_q <= '0;
                R_WAIT:  wait_q <= wait_q + 2'd1;
                R_DRAIN: if (m_hs) begin
                    if (last_word) begin
                        wcnt_q <= '0;
                        lcnt_q <= lcnt_q + LINE_ONE;
                        addr_q <= addr_q + ADDR_ONE;
                    end else begin
                        wcnt_q <= wcnt_q + WORD_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    axis_bram_line_buf #(
        .WORD_W         (WORD_W),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_buf (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .wr_en   (s_hs),
        .wr_idx  (wcnt_q),
        .wr_word (bus.s_axis_tdata),
        .ld_en   (capture),
        .ld_line (bus.bram_rdata),
        .rd_idx  (wcnt_q),
        .rd_word (rd_word),
        .line    (line)
    );

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.err_tlast     = err_q;
    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = m_valid ? rd_word : '0;
    assign bus.m_axis_tlast  = m_valid && final_word;
    assign bus.bram_en       = bram_en;
    assign bus.bram_we       = bram_we;
    assign bus.bram_addr     = addr_q;
    assign bus.bram_wdata    = line;

endmodule

// File: tb/tb_axis_bram_stream_engine.sv
// Directed bench for axis_bram_stream_engine with a behavioural BRAM and
// scoreboard queues for BRAM writes, BRAM reads and output stream words.
module tb_axis_bram_stream_engine;
    localparam int WORD_W = 16;
    localparam int WPL    = 4;
    localparam int ADDR_W = 9;
    localparam int RDL    = 3;
    localparam int LINE_W = WORD_W * WPL;
    localparam logic [LINE_W-1:0] POISON = 64'hBAD0_BAD1_BAD2_BAD3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axis_bram_stream_engine_if #(.WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W)) bus ();

    axis_bram_stream_engine #(
        .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W), .RD_LATENCY(RDL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [LINE_W-1:0] rd_pipe [0:RDL-1];
    logic [ADDR_W-1:0] wr_addr_log[$], rd_addr_log[$], exp_waddr[$], exp_raddr[$];
    logic [LINE_W-1:0] wr_data_log[$], exp_wdata[$];
    logic [WORD_W:0]   exp_stream[$];

    // BRAM model: reads return data RDL cycles after the enable, poison otherwise.
    always @(posedge clk) begin
        if (bus.bram_en && bus.bram_we) begin
            mem[bus.bram_addr] <= bus.bram_wdata;
            wr_addr_log.push_back(bus.bram_addr);
            wr_data_log.push_back(bus.bram_wdata);
        end
        if (bus.bram_en && !bus.bram_we) rd_addr_log.push_back(bus.bram_addr);
        rd_pipe[0] <= (bus.bram_en && !bus.bram_we) ? mem[bus.bram_addr] : POISON;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.bram_rdata = rd_pipe[RDL-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] pack(input int w0, input int w1, input int w2, input int w3);
        return {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
    endfunction

    task automatic start_job(input logic m, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.base_addr = b;
        bus.num_lines = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic l);
        int n = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = l;
        while (!bus.s_axis_tready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout observed=no_tready expected=tready word=%0h", d);
        end
        step();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic push_stream(input int first, input int count);
        for (int i = 0; i < count; i++)
            exp_stream.push_back({(i == count - 1), 16'(first + i)});
    endtask

    task automatic drain(input bit toggle);
        int cyc = 0;
        logic stalled = 1'b0;
        logic [WORD_W-1:0] held = '0;
        logic [WORD_W:0] e;
        while (exp_stream.size() > 0 && cyc < 300) begin
            bus.m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (bus.m_axis_tvalid) begin
                if (stalled) chk("hold_data", 64'(bus.m_axis_tdata), 64'(held));
                if (bus.m_axis_tready) begin
                    e = exp_stream.pop_front();
                    chk("stream_data", 64'(bus.m_axis_tdata), 64'(e[WORD_W-1:0]));
                    chk("stream_last", 64'(bus.m_axis_tlast), 64'(e[WORD_W]));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.m_axis_tdata;
                end
            end
            step();
            cyc++;
        end
        bus.m_axis_tready = 1'b0;
        if (exp_stream.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout observed=%0d_left expected=0_left", exp_stream.size());
            exp_stream.delete();
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(bus.done), 64'(1));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
        step();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 64'(wr_addr_log.size()), 64'(exp_waddr.size()));
        while (exp_waddr.size() > 0 && wr_addr_log.size() > 0) begin
            chk({tag, "_wr_addr"}, 64'(wr_addr_log.pop_front()), 64'(exp_waddr.pop_front()));
            chk({tag, "_wr_data"}, wr_data_log.pop_front(), exp_wdata.pop_front());
        end
        exp_waddr.delete(); exp_wdata.delete(); wr_addr_log.delete(); wr_data_log.delete();
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_rd_count"}, 64'(rd_addr_log.size()), 64'(exp_raddr.size()));
        while (exp_raddr.size() > 0 && rd_addr_log.size() > 0)
            chk({tag, "_rd_addr"}, 64'(rd_addr_log.pop_front()), 64'(exp_raddr.pop_front()));
        exp_raddr.delete(); rd_addr_log.delete();
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.num_lines = '0;
        bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < RDL; i++) rd_pipe[i] = POISON;

        #3;
        chk("rst_busy",   64'(bus.busy), 64'(0));
        chk("rst_done",   64'(bus.done), 64'(0));
        chk("rst_err",    64'(bus.err_tlast), 64'(0));
        chk("rst_tready", 64'(bus.s_axis_tready), 64'(0));
        chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        chk("rst_en",     64'(bus.bram_en), 64'(0));
        chk("rst_addr",   64'(bus.bram_addr), 64'(0));
        chk("rst_wdata",  bus.bram_wdata, 64'(0));
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        step();

        // two-line write, base 5, words 1..8
        exp_waddr.push_back(9'd5); exp_wdata.push_back(pack(1, 2, 3, 4));
        exp_waddr.push_back(9'd6); exp_wdata.push_back(pack(5, 6, 7, 8));
        start_job(1'b1, 9'd5, 9'd2);
        chk("w2_busy", 64'(bus.busy), 64'(1));
        for (int i = 1; i <= 8; i++) send_word(16'(i), i == 8);
        wait_done("w2");
        chk("w2_err", 64'(bus.err_tlast), 64'(0));
        check_writes("w2");

        // read them back with toggling tready
        exp_raddr.push_back(9'd5); exp_raddr.push_back(9'd6);
        push_stream(1, 8);
        start_job(1'b0, 9'd5, 9'd2);
        drain(1'b1);
        wait_done("r2");
        check_reads("r2");

        // early tlast on word 3 of a two-line job
        exp_waddr.push_back(9'd20); exp_wdata.push_back(pack(1, 2, 3, 0));
        start_job(1'b1, 9'd20, 9'd2);
        for (int i = 1; i <= 3; i++) send_word(16'(i), i == 3);
        wait_done("early");
        chk("early_err", 64'(bus.err_tlast), 64'(1));
        chk("early_tready", 64'(bus.s_axis_tready), 64'(0));
        step();
        chk("early_tready2", 64'(bus.s_axis_tready), 64'(0));
        check_writes("early");

        // address wrap from 511 to 0
        exp_waddr.push_back(9'd511); exp_wdata.push_back(pack(11, 12, 13, 14));
        exp_waddr.push_back(9'd0);   exp_wdata.push_back(pack(15, 16, 17, 18));
        start_job(1'b1, 9'd511, 9'd2);
        for (int i = 11; i <= 18; i++) send_word(16'(i), i == 18);
        wait_done("wrap");
        chk("wrap_err", 64'(bus.err_tlast), 64'(0));
        check_writes("wrap");

        // missing tlast on the final word
        exp_waddr.push_back(9'd40); exp_wdata.push_back(pack(21, 22, 23, 24));
        start_job(1'b1, 9'd40, 9'd1);
        for (int i = 21; i <= 24; i++) send_word(16'(i), 1'b0);
        wait_done("miss");
        chk("miss_err", 64'(bus.err_tlast), 64'(1));
        check_writes("miss");

        // zero-length job
        start_job(1'b1, 9'd50, 9'd0);
        chk("zero_done", 64'(bus.done), 64'(1));
        chk("zero_busy", 64'(bus.busy), 64'(0));
        chk("zero_err_cleared", 64'(bus.err_tlast), 64'(0));
        step();
        chk("zero_done_pulse", 64'(bus.done), 64'(0));
        check_writes("zero");
        check_reads("zero");

        // start while busy is ignored
        exp_raddr.push_back(9'd5);
        push_stream(1, 4);
        start_job(1'b0, 9'd5, 9'd1);
        start_job(1'b1, 9'd100, 9'd7);
        drain(1'b0);
        wait_done("ign");
        check_reads("ign");
        check_writes("ign");

        // reset in the middle of R_DRAIN, then a clean read
        start_job(1'b0, 9'd5, 9'd2);
        n = 0;
        while (!bus.m_axis_tvalid && n < 20) begin
            step();
            n++;
        end
        chk("pre_rst_valid", 64'(bus.m_axis_tvalid), 64'(1));
        chk("pre_rst_data",  64'(bus.m_axis_tdata), 64'(1));
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy",   64'(bus.busy), 64'(0));
        chk("mid_rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        chk("mid_rst_tdata",  64'(bus.m_axis_tdata), 64'(0));
        chk("mid_rst_en",     64'(bus.bram_en), 64'(0));
        chk("mid_rst_addr",   64'(bus.bram_addr), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        step();
        rd_addr_log.delete();
        exp_raddr.push_back(9'd6);
        push_stream(5, 4);
        start_job(1'b0, 9'd6, 9'd1);
        drain(1'b1);
        wait_done("post_rst");
        check_reads("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
